// File: rtl/dcache_pkg.sv
// Shared constants and helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int OFFSET_W = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines);
    return addr_w - OFFSET_W - $clog2(lines);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signals of the data cache, plus its state for observation.
// Memory handshake: the cache holds mem_stall (with mem_MemRead or mem_WE) and a stable
// address/data until it samples a one-cycle mem_ready pulse; mem_ready is ignored otherwise.
interface dcache_ctrl_if #(
  parameter int ADDR_W  = 10,
  parameter int BLOCK_W = 128
);
  logic               MemRead;
  logic               MemWrite;
  logic [ADDR_W-1:0]  word_address;
  logic [31:0]        data_in;
  logic [31:0]        data_out;
  logic               stall;
  logic [ADDR_W-1:0]  mem_word_address;
  logic [31:0]        mem_data_in;
  logic               mem_WE;
  logic               mem_MemRead;
  logic               mem_stall;
  logic [BLOCK_W-1:0] mem_RD;
  logic               mem_ready;
  logic [15:0]        hit_count;
  logic [15:0]        miss_count;
  logic [1:0]         state_dbg;

  modport slave (
    input  MemRead, MemWrite, word_address, data_in, mem_RD, mem_ready,
    output data_out, stall, mem_word_address, mem_data_in, mem_WE, mem_MemRead,
           mem_stall, hit_count, miss_count, state_dbg
  );

  modport master (
    output MemRead, MemWrite, word_address, data_in, mem_RD, mem_ready,
    input  data_out, stall, mem_word_address, mem_data_in, mem_WE, mem_MemRead,
           mem_stall, hit_count, miss_count, state_dbg
  );
endinterface

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage with combinational lookup, a whole-line fill port and a word write port.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int LINES   = 32,
  parameter int BLOCK_W = 128,
  parameter int ADDR_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  lookup_addr,
  output logic               hit,
  output logic [31:0]        lookup_word,
  input  logic               fill_en,
  input  logic [ADDR_W-1:0]  fill_addr,
  input  logic [BLOCK_W-1:0] fill_data,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [31:0]        wr_data
);
  localparam int IDX_W = index_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES);

  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tags [LINES];
  logic [BLOCK_W-1:0] data [LINES];

  logic [IDX_W-1:0]    lk_idx, fill_idx, wr_idx;
  logic [TAG_W-1:0]    lk_tag, fill_tag;
  logic [OFFSET_W-1:0] lk_off, wr_off;

  assign lk_idx   = lookup_addr[OFFSET_W +: IDX_W];
  assign lk_tag   = lookup_addr[ADDR_W-1 -: TAG_W];
  assign lk_off   = lookup_addr[OFFSET_W-1:0];
  assign fill_idx = fill_addr[OFFSET_W +: IDX_W];
  assign fill_tag = fill_addr[ADDR_W-1 -: TAG_W];
  assign wr_idx   = wr_addr[OFFSET_W +: IDX_W];
  assign wr_off   = wr_addr[OFFSET_W-1:0];

  assign hit         = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign lookup_word = data[lk_idx][32*lk_off +: 32];

  // Only the valid bits are reset; stale tags/data are harmless behind a cleared valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= fill_data;
    end else if (wr_en) begin
      data[wr_idx][32*wr_off +: 32] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller and hit/miss statistics.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES   = 32,
  parameter int BLOCK_W = 128,
  parameter int ADDR_W  = 10
) (
  input logic         clk,
  input logic         rst,
  dcache_ctrl_if.slave bus
);
  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [15:0]       hit_cnt, miss_cnt;
  logic              just_filled;
  logic              hit;
  logic [31:0]       word;
  logic              idle_rd, idle_wr, fill_en, wr_en;
  logic              stall_c;

  assign idle_rd = (state == S_IDLE) && bus.MemRead && !bus.MemWrite;
  assign idle_wr = (state == S_IDLE) && bus.MemWrite;
  assign fill_en = (state == S_FILL) && bus.mem_ready;
  assign wr_en   = idle_wr && hit;

  dcache_line_array #(
    .LINES(LINES), .BLOCK_W(BLOCK_W), .ADDR_W(ADDR_W)
  ) u_lines (
    .clk        (clk),
    .rst        (rst),
    .lookup_addr(bus.word_address),
    .hit        (hit),
    .lookup_word(word),
    .fill_en    (fill_en),
    .fill_addr  (addr_q),
    .fill_data  (bus.mem_RD),
    .wr_en      (wr_en),
    .wr_addr    (bus.word_address),
    .wr_data    (bus.data_in)
  );

  always_comb begin
    stall_c = 1'b0;
    case (state)
      S_IDLE:  stall_c = bus.MemWrite || (bus.MemRead && !hit);
      S_FILL:  stall_c = 1'b1;
      S_WRITE: stall_c = 1'b1;
      default: stall_c = 1'b0;
    endcase
  end

  // Strobes come straight from the state register so an async reset drops them at once.
  assign bus.stall            = stall_c;
  assign bus.data_out         = (idle_rd && hit) ? word : 32'd0;
  assign bus.mem_MemRead      = (state == S_FILL);
  assign bus.mem_WE           = (state == S_WRITE);
  assign bus.mem_stall        = (state == S_FILL) || (state == S_WRITE);
  assign bus.mem_word_address = addr_q;
  assign bus.mem_data_in      = data_q;
  assign bus.hit_count        = hit_cnt;
  assign bus.miss_count       = miss_cnt;
  assign bus.state_dbg        = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      just_filled <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          just_filled <= 1'b0;
          if (idle_wr) begin
            addr_q <= bus.word_address;
            data_q <= bus.data_in;
            state  <= S_WRITE;
            if (hit) hit_cnt  <= sat_inc(hit_cnt);
            else     miss_cnt <= sat_inc(miss_cnt);
          end else if (idle_rd) begin
            if (hit) begin
              // The lookup right after a fill is the original miss completing, not a new hit.
              if (!just_filled) hit_cnt <= sat_inc(hit_cnt);
            end else begin
              addr_q   <= bus.word_address;
              state    <= S_FILL;
              miss_cnt <= sat_inc(miss_cnt);
            end
          end
        end
        S_FILL: begin
          if (bus.mem_ready) begin
            state       <= S_IDLE;
            just_filled <= 1'b1;
          end
        end
        S_WRITE: begin
          if (bus.mem_ready) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus random loads/stores against a word-level reference.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  localparam int LINES   = 32;
  localparam int BLOCK_W = 128;
  localparam int ADDR_W  = 10;
  localparam int WORDS   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;

  dcache_ctrl_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();

  dcache_ctrl #(.LINES(LINES), .BLOCK_W(BLOCK_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory behind the cache, and the value every load must return (write-through keeps them coherent).
  logic [31:0] mem_words [WORDS];
  logic [31:0] ref_mem   [WORDS];
  bit          m_valid   [LINES];
  int          m_tag     [LINES];
  int          exp_hits, exp_misses;
  logic [31:0] exp_q[$];

  int lat      = 4;
  int last_lat = 4;
  int mcnt     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BLOCK_W-1:0] block_of(input logic [ADDR_W-1:0] a);
    int base;
    base = (int'(a) / 4) * 4;
    return {mem_words[base+3], mem_words[base+2], mem_words[base+1], mem_words[base]};
  endfunction

  function automatic int line_of(input logic [ADDR_W-1:0] a);
    return (int'(a) / 4) % LINES;
  endfunction

  function automatic int tag_of(input logic [ADDR_W-1:0] a);
    return int'(a) / (4 * LINES);
  endfunction

  function automatic bit m_hit(input logic [ADDR_W-1:0] a);
    return m_valid[line_of(a)] && (m_tag[line_of(a)] == tag_of(a));
  endfunction

  // Memory responder: counts mem_stall cycles and pulses mem_ready after lat of them.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_RD    = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        mcnt = 0;
      end else if (bus.mem_stall) begin
        mcnt++;
        if (mcnt >= lat) begin
          if (bus.mem_MemRead) bus.mem_RD = block_of(bus.mem_word_address);
          if (bus.mem_WE) mem_words[bus.mem_word_address] = bus.mem_data_in;
          bus.mem_ready = 1'b1;
          last_lat = lat;
          lat = $urandom_range(1, 5);
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  task automatic check_counts(input string tag);
    check({tag, "_hits"}, {16'd0, bus.hit_count}, exp_hits);
    check({tag, "_misses"}, {16'd0, bus.miss_count}, exp_misses);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    bit h;
    int n;
    h = m_hit(a);
    @(negedge clk);
    bus.MemRead = 1'b1; bus.MemWrite = 1'b0; bus.word_address = a;
    #1;
    exp_q.push_back(ref_mem[a]);
    check("rd_stall", {31'd0, bus.stall}, {31'd0, !h});
    n = 0;
    while (bus.stall && n < 100) begin
      @(negedge clk); #1;
      n++;
      if (n == 1) begin
        check("fill_memread", {31'd0, bus.mem_MemRead}, 32'd1);
        check("fill_addr", {22'd0, bus.mem_word_address}, {22'd0, a});
      end
    end
    check("rd_stall_end", {31'd0, bus.stall}, 32'd0);
    if (h) begin
      exp_hits++;
    end else begin
      check("rd_miss_cycles", n, 1 + last_lat);
      exp_misses++;
      m_valid[line_of(a)] = 1'b1;
      m_tag[line_of(a)]   = tag_of(a);
    end
    check("rd_data", bus.data_out, exp_q.pop_front());
    @(negedge clk);
    bus.MemRead = 1'b0;
    #1;
    check_counts("rd");
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bit h;
    int n;
    h = m_hit(a);
    @(negedge clk);
    bus.MemWrite = 1'b1; bus.MemRead = 1'($urandom_range(0, 1));
    bus.word_address = a; bus.data_in = d;
    #1;
    check("wr_stall", {31'd0, bus.stall}, 32'd1);
    ref_mem[a] = d;
    if (h) exp_hits++;
    else   exp_misses++;
    n = 0;
    while (bus.stall && n < 100) begin
      @(negedge clk); #1;
      n++;
      if (n == 1) begin
        check("wr_we", {31'd0, bus.mem_WE}, 32'd1);
        check("wr_mem_data", bus.mem_data_in, d);
        // A changing CPU request while stalled must not disturb the latched store.
        bus.word_address = ADDR_W'($urandom_range(0, WORDS - 1));
        bus.data_in      = $urandom;
      end
    end
    check("wr_cycles", n, 1 + last_lat);
    check("wr_done_memstall", {31'd0, bus.mem_stall}, 32'd0);
    check("wr_addr_stable", {22'd0, bus.mem_word_address}, {22'd0, a});
    bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
    #1;
    check_counts("wr");
  endtask

  task automatic do_reset_abort(input logic [ADDR_W-1:0] a);
    lat = 20;
    @(negedge clk);
    bus.MemRead = 1'b1; bus.MemWrite = 1'b0; bus.word_address = a;
    repeat (3) @(negedge clk);
    #1;
    check("abort_pre_memread", {31'd0, bus.mem_MemRead}, 32'd1);
    rst = 1'b1;
    bus.MemRead = 1'b0;
    #1;
    check("abort_memread", {31'd0, bus.mem_MemRead}, 32'd0);
    check("abort_memstall", {31'd0, bus.mem_stall}, 32'd0);
    check("abort_stall", {31'd0, bus.stall}, 32'd0);
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    exp_hits = 0; exp_misses = 0;
    check_counts("abort");
    @(negedge clk);
    rst = 1'b0;
    lat = 4;
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < WORDS; i++) begin
      mem_words[i] = $urandom;
      ref_mem[i]   = mem_words[i];
    end
    mem_words[4] = 32'h0000AAAA; mem_words[5] = 32'h0000BBBB;
    mem_words[6] = 32'h0000CCCC; mem_words[7] = 32'h0000DDDD;
    for (int i = 4; i < 8; i++) ref_mem[i] = mem_words[i];
    for (int i = 0; i < LINES; i++) begin m_valid[i] = 1'b0; m_tag[i] = 0; end
    exp_hits = 0; exp_misses = 0;

    rst = 1'b1;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.word_address = '0; bus.data_in = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_we", {31'd0, bus.mem_WE}, 32'd0);
    check("rst_memread", {31'd0, bus.mem_MemRead}, 32'd0);
    check("rst_memstall", {31'd0, bus.mem_stall}, 32'd0);
    check("rst_addr", {22'd0, bus.mem_word_address}, 32'd0);
    check("rst_wdata", bus.mem_data_in, 32'd0);
    check("rst_dout", bus.data_out, 32'd0);
    check_counts("rst");
    rst = 1'b0;

    lat = 4;
    do_read(10'h004);
    do_read(10'h005);
    do_read(10'h007);
    do_write(10'h006, 32'hDEADBEEF);
    do_read(10'h006);
    do_write(10'h3F0, 32'h12345678);
    do_read(10'h3F0);
    do_read(10'h084);
    do_read(10'h004);

    // A stray mem_ready while idle must not start anything.
    @(negedge clk);
    bus.mem_ready = 1'b1;
    @(negedge clk); #1;
    check("stray_ready_memstall", {31'd0, bus.mem_stall}, 32'd0);
    check("stray_ready_stall", {31'd0, bus.stall}, 32'd0);
    do_read(10'h004);

    do_reset_abort(10'h084);
    do_read(10'h084);

    for (int k = 0; k < 300; k++) begin
      a = ADDR_W'(($urandom_range(0, 7) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 9) < 7) do_read(a);
      else                          do_write(a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache that sits between the CPU load/store stage and the block-organised data memory. It is the initiator of the memory's stall/ready block-fill protocol. On a read miss it holds the CPU, requests a 128-bit block, waits for `mem_ready`, and installs the line. On every store it forwards the word to memory under the same handshake.

## Interface
- `LINES`, 32: number of cache lines. Power of two; index width is log2(LINES).
- `BLOCK_W`, 128: line width, four 32-bit words; must match the memory block width.
- `ADDR_W`, 10: word-address width; tag width is ADDR_W − 2 − log2(LINES) (3 at defaults).
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `MemRead` in 1: CPU load request.
- `MemWrite` in 1: CPU store request; wins if asserted together with `MemRead`.
- `word_address` in ADDR_W: CPU word address; [1:0] offset, next bits index, top bits tag.
- `data_in` in 32: store data.
- `data_out` out 32: load data; valid when `MemRead` and `stall`=0.
- `stall` out 1: freeze CPU pipeline.
- `mem_word_address` out ADDR_W: registered request address to memory.
- `mem_data_in` out 32: registered store data to memory.
- `mem_WE` out 1: memory write enable.
- `mem_MemRead` out 1: memory block read enable.
- `mem_stall` out 1: request-in-progress to memory; drives its ready counter.
- `mem_RD` in BLOCK_W: block read from memory.
- `mem_ready` in 1: memory transfer complete, one-cycle pulse.
- `hit_count`, `miss_count` out 16 each: saturating statistics counters.

## Operation
- Storage per line: valid bit, tag, BLOCK_W data. Hit = valid and tag equal at the addressed index.
- States: IDLE, FILL, WRITE, DONE.
- IDLE:
  - Read hit: `data_out` = word at offset, combinational; `stall`=0; `hit_count`+1.
  - Read miss: `stall`=1 combinationally; latch address; go to FILL; `miss_count`+1.
  - Store, hit or miss: `stall`=1; latch address and data; go to WRITE. On a hit, update the cached word at the offset in the same edge. On a miss, no allocation. Stores count as hit or miss by lookup.
- FILL: `stall`=`mem_stall`=`mem_MemRead`=1. On the posedge where `mem_ready`=1: write `mem_RD` into the line, set valid, write tag, go to IDLE. The request then hits, and `stall` falls in that cycle.
- WRITE: `stall`=`mem_stall`=`mem_WE`=1. On `mem_ready`=1, go to DONE.
- DONE: `stall`=0 for one cycle; the current request is treated as completed and not re-issued. Return to IDLE.
- Neither request asserted: idle, `stall`=0, counters unchanged.
- Counters saturate at 16'hFFFF. They are not incremented by the re-lookup after a fill.
- `mem_ready` outside FILL/WRITE is ignored.

## Timing
- Reset values, applied asynchronously: state IDLE, all valid bits 0; `stall`, `mem_WE`, `mem_MemRead`, `mem_stall` = 0; `mem_word_address`, `mem_data_in`, `data_out`, counters = 0. Line data and tags are not reset.
- Read hit latency: 0 cycles.
- Read miss: 1 cycle to enter FILL, plus memory latency (4 cycles of `mem_stall` at the current memory), then data on the following cycle.
- `mem_word_address` and `mem_data_in` are stable for the whole FILL/WRITE period.
- `mem_stall` stays high continuously until the edge that samples `mem_ready`=1, then drops in the next cycle.
- Reset mid-FILL or mid-WRITE: abort. The line is not marked valid and all memory strobes drop immediately.
- CPU request changing while `stall`=1: ignored; the latched request completes.

## Structure
- Package `dcache_pkg`:
  - state enum {IDLE, FILL, WRITE, DONE};
  - offset width 2;
  - functions for index and tag width from LINES/ADDR_W.
- Sub-module `dcache_line_array`:
  - valid/tag/data storage with combinational lookup (hit, word);
  - line fill port and word write port;
  - async valid clear on `rst`.
- The FSM and counters live in `dcache_ctrl`.

## Test plan
- Cold read of address 0x004 after reset → `stall` high 1 cycle before FILL; `mem_MemRead` held until `mem_ready`. With `mem_RD`=128'h…_DDDD_CCCC_BBBB_AAAA, line 1 is filled; `stall` then drops and `data_out`=32'hAAAA (offset 0). `miss_count`=1.
- Re-read 0x005 and 0x007 → `stall`=0, `data_out`=word1 then word3; `hit_count`=2.
- Store 32'hDEADBEEF to 0x006 (line hit) → `mem_WE`/`mem_stall` until ready, one DONE cycle. A later read of 0x006 hits with 32'hDEADBEEF.
- Store to 0x3F0 (miss), then read 0x3F0 → store does not allocate; the read misses and fills.
- Conflicting read 0x084 after 0x004 (same index 1, tag 1 vs 0) → miss and refill; 0x004 then misses again.
- Assert `rst` two cycles into FILL → strobes low immediately, valid clear; the subsequent read of the same address misses.
